// File: rtl/alu_operand_sequencer.sv
// Issue/writeback sequencer around the processor ALU: decodes instruction words,
// drives ALU operands from the accumulator and register file, writes results back.
module alu_operand_sequencer #(
    parameter int NREGS = 8,
    parameter int IMM_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] alout,
    output logic [31:0] acout,
    output logic [31:0] B_in,
    output logic [2:0]  opcode,
    output logic        alu_start,
    output logic [31:0] acc,
    output logic        retire,
    output logic        busy
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [2:0] OP_STORE = 3'b111;

    typedef enum logic [1:0] {IDLE, READY, ISSUE, WAIT} state_t;

    state_t      state, state_next;
    logic [31:0] regs [NREGS];
    logic [31:0] ir_p0;
    logic        stop_seen;

    logic [2:0]       ir_op;
    logic [IDX_W-1:0] ir_idx;
    logic [IDX_W-1:0] in_idx;
    logic [31:0]      in_imm;

    assign ir_op  = ir_p0[31:29];
    assign ir_idx = ir_p0[27:28-IDX_W];
    assign in_idx = instr[27:28-IDX_W];
    assign in_imm = {{(32-IMM_W){1'b0}}, instr[IMM_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READY;
            READY: begin
                if (instr_valid)  state_next = ISSUE;
                else if (stop)    state_next = IDLE;
            end
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = (stop_seen || stop) ? IDLE : READY;
            default: state_next = IDLE;
        endcase
    end

    // rst masks retire so a discarded instruction never reports completion
    always_comb begin
        instr_ready = (state == READY);
        retire      = (state == WAIT) && !rst;
        busy        = (state != IDLE);
        alu_start   = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            acout     <= '0;
            B_in      <= '0;
            ir_p0     <= '0;
            opcode    <= OP_STORE;
            stop_seen <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                READY: begin
                    // accept: operands are loaded so the ALU sees them throughout ISSUE
                    if (instr_valid) begin
                        ir_p0     <= instr;
                        opcode    <= instr[31:29];
                        acout     <= acc;
                        B_in      <= instr[28] ? in_imm : regs[in_idx];
                        stop_seen <= stop;
                    end
                end
                ISSUE: begin
                    stop_seen <= stop_seen | stop;
                end
                WAIT: begin
                    if (ir_op == OP_STORE) begin
                        regs[ir_idx] <= acc;
                    end else begin
                        acc <= alout;
                    end
                    opcode <= OP_STORE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Multicycle issue/writeback stage directly upstream and downstream of the processor ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Holds the accumulator and an 8-entry register file, drives the ALU operands (acout, B_in) and opcode, and writes the registered ALU result (alout) back into the accumulator.
- Handles the ALU store opcode (111) by writing the accumulator into the register file.

Parameters:
NREGS, 8, register file depth; index field width is log2(NREGS) = 3.
IMM_W, 16, immediate width; zero-extended to 32 bits.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin fetching instructions; sampled only in IDLE.
stop  in  1  return to IDLE after the in-flight instruction retires.
instr  in  32  instruction word: [31:29] op, [28] src (0 = regfile, 1 = imm), [27:25] idx, [15:0] imm.
instr_valid  in  1  instr is valid this cycle.
instr_ready  out  1  sequencer accepts instr this cycle.
alout  in  32  registered ALU result.
acout  out  32  accumulator operand to the ALU.
B_in  out  32  second operand to the ALU.
opcode  out  3  ALU opcode.
alu_start  out  1  ALU enable; 0 only in IDLE.
acc  out  32  current accumulator value.
retire  out  1  one-cycle pulse when an instruction completes.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - acc, all regfile entries, acout, B_in, latched instruction = 0.
  - opcode=3'b111 (ALU hold).
  - instr_ready, retire, busy, alu_start = 0.
  - rst overrides all other inputs, including mid-instruction; the in-flight instruction is discarded with no writeback.
- States: IDLE, READY, ISSUE, WAIT.
  - IDLE: start=1 -> READY. instr_valid is ignored; instr_ready=0.
  - READY: instr_ready=1, combinational from state. On instr_valid&&instr_ready, latch instr -> ISSUE. If stop=1 and no handshake -> IDLE.
  - ISSUE: instr_ready=0. Registered outputs already hold opcode=op, acout=acc, and B_in = src ? {16'b0, imm} : regfile[idx]; these are loaded on the accepting edge. The ALU captures its result on the edge ending ISSUE. -> WAIT.
  - WAIT: alout is valid. On the edge ending WAIT:
    - op!=111: acc <= alout.
    - op==111: regfile[idx] <= acc, acc unchanged.
    - retire=1 for exactly this WAIT cycle.
    - Next state: stop seen at any time since accept (sticky flag) or stop=1 now -> IDLE; otherwise READY.
- Latency and throughput:
  - Accept edge -> acc updated 2 edges later.
  - One instruction per 3 cycles maximum.
- Operand hazards:
  - B_in is read from regfile at accept. A store to the same idx in the preceding instruction is already committed, because the WAIT write precedes the next READY.
- Register outputs:
  - opcode, acout and B_in hold their values outside ISSUE.
  - opcode returns to 111 in READY/IDLE so the ALU holds alout.
- Arithmetic: no overflow handling; the ALU wraps mod 2^32. op 000 yields acc=0 via alout.
- Simultaneous events:
  - start while busy: ignored.
  - start and stop together in IDLE: start wins -> READY.
  - stop in READY with a handshake in the same cycle: the instruction is accepted and executed, then IDLE.
- idx is always valid for NREGS=8; bits [24:16] are reserved and ignored.

Test Plan:
1. Reset then start; immediate add: instr={010,1,000,...,imm=16'd5}, then {010,1,...,imm=7} -> acc=5 after first retire, acc=12 after second; retire pulses 3 cycles apart.
2. Store and reuse: acc=12; {111,0,idx=3} -> regfile[3]=12, acc stays 12; then {011,0,idx=3} -> acc=0.
3. Logic ops: acc=0xF0F0F0F0; {101,1,imm=0x00FF} -> acc=0x000000F0; {110,1,imm=0x0FF0} -> acc=0x00000F00; {100,1,imm=0x000F} -> acc=0x00000F0F.
4. Mask/clear: {001,1,imm=0x00FF} -> acc=0x000000FF (8 ones); {000,...} -> acc=0.
5. Handshake/stop: hold instr_valid=0 in READY for 4 cycles -> no retire, acc unchanged. Assert stop during ISSUE -> instruction retires, then busy=0 and instr_ready=0.
6. Reset mid-operation: assert rst in WAIT of an add with acc=5, imm=9 -> next cycle acc=0, state IDLE, retire never pulses, regfile cleared.
